rxframer: RTL
=============

// Module: rxframer
// PURPOSE
//  Receive-side STM-1 overhead framer, counterpart of the transmit framer. Accepts the byte-wide
//  overhead stream (FRM_LEN byte slots per frame, qualified by en) and locates A1A1A1A2A2A2.
//  Runs a HUNT/PRESYNC/SYNC alignment FSM and extracts B1, B2 (3 bytes), K1/K2 and M1.
//  Feeds the BIP checkers and the transmit-side M1/REI path.
// PARAMETERS
//  FRM_LEN    72  byte slots per frame; slot 0 = first A1
//  ALIGN_CNT  2   consecutive good frame words in PRESYNC before SYNC
//  LOSS_CNT   4   consecutive bad frame words in SYNC before HUNT
//  LOF_FRM    8   frames of continuous OOF before lof asserts (RXFR_LOF_EN only)
// PORTS
//  clk19    in   1   19.44 MHz byte clock
//  rst_n    in   1   synchronous reset, active-low
//  rdat     in   8   received byte
//  en       in   1   rdat valid this cycle; all counting and state advance only when en=1
//  rxsof    out  1   1-cycle pulse: frame word confirmed at slot 5 (PRESYNC/SYNC only)
//  oof      out  1   out-of-frame: 1 in HUNT and PRESYNC
//  lof      out  1   loss-of-frame (RXFR_LOF_EN); tied 0 otherwise
//  b1dat    out  8   B1 byte (slot 9);                b1vld out 1  1-cycle pulse
//  b2dat    out  24  B2 slots 27,28,29 -> [23:16],[15:8],[7:0]; b2vld out 1  pulse after slot 29
//  k1k2     out  16  {K1 slot 30, K2 slot 33}; updated only in SYNC
//  m1dat    out  8   M1 byte (slot 68);               m1vld out 1  1-cycle pulse
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge, overrides all): state=HUNT, slot=0, oof=1, lof=0, all data outputs 0,
//   all pulses 0, shift register cleared.
//  48-bit shift register takes rdat on each en cycle; match = {A1,A1,A1,A2,A2,A2} (F6F6F6282828).
//  Slot counter 7-bit, 0..FRM_LEN-1; it wraps FRM_LEN-1 -> 0 on en.
//   HUNT: slot is free-running and ignored. On a match the byte just accepted is slot 5,
//   so the counter loads 6 and the FSM goes to PRESYNC with good=1.
//  PRESYNC: at slot 5, match -> good+1, rxsof pulse; good==ALIGN_CNT -> SYNC.
//   No match at slot 5 -> HUNT, and the same-cycle match check is not re-evaluated.
//  SYNC: at slot 5, match -> bad=0, rxsof; no match -> bad+1, rxsof stays 0.
//   bad==LOSS_CNT -> HUNT, oof=1 next cycle. Fewer than LOSS_CNT bad words keeps SYNC and slot phase.
//  Extraction (PRESYNC and SYNC only, never in HUNT):
//   - Output registered; vld pulses one clk after the en-cycle carrying the byte.
//   - b2vld only after all of slots 27..29 are captured in the same frame.
//   - HUNT entry mid-B2 discards the partial b2 and leaves b2dat unchanged.
//  en=0 cycles: no slot advance, no shift, pulses low; gaps of any length are tolerated.
//  oof is registered and follows the state one cycle late.
//   Outputs hold their last value across HUNT and are not cleared on loss.
// CONFIGURATION
//  `RXFR_LOF_EN defined:
//   - frame counter increments at each slot wrap while oof=1 (HUNT uses its free-running slot).
//   - lof=1 when the count reaches LOF_FRM.
//   - lof clears after ALIGN_CNT+LOSS_CNT frames in SYNC with no bad word; counter resets when oof=0.
//  Undefined: no counter logic, lof tied 0.
// STRUCTURE
//  Shared header stm_oh_defs.vh:
//   - A1/A2 constants
//   - slot constants: SLOT_A2L=5, SLOT_B1=9, SLOT_B2=27, SLOT_K1=30, SLOT_K2=33, SLOT_M1=68
//   - FSM state encodings HUNT=0, PRESYNC=1, SYNC=2
//   The tx framer uses the same header.
//  One sub-module rxfr_align: shift register + match + FSM + slot counter; outputs slot, state, rxsof.
//  Top level does extraction and LOF.
// TESTING
//  1. Reset, then clean frames with A1/A2 at slot 0:
//     oof=0 after 2nd frame word; rxsof every 72 en-cycles; B1=0x5A -> b1dat=0x5A, b1vld 1 clk after slot 9.
//  2. In SYNC, corrupt A2 in 3 consecutive frames:
//     stays SYNC, no rxsof in those frames. 4th corrupt -> oof=1, no further b1vld.
//  3. In PRESYNC, a false A1A2 pattern inside the data is followed by a bad slot 5 -> back to HUNT;
//     true alignment then found.
//  4. B2 = 0x123456 and M1 = 0x07 with random en gaps -> b2dat=0x123456 with one b2vld;
//     m1dat=0x07 with one m1vld.
//  5. rst_n low mid-frame in SYNC -> next cycle all outputs at reset values, oof=1.
//  6. `RXFR_LOF_EN with no pattern for 8 frames -> lof=1; realign and hold SYNC 6 frames -> lof=0.

Source files
------------

// File: rtl/rxframer_pkg.sv
// Shared STM-1 overhead definitions for the rx/tx framers:
// framing bytes, overhead slot positions and alignment state codes.
package rxframer_pkg;

    localparam logic [7:0]  A1         = 8'hF6;
    localparam logic [7:0]  A2         = 8'h28;
    localparam logic [47:0] FRAME_WORD = {A1, A1, A1, A2, A2, A2};

    localparam logic [6:0] SLOT_A2L = 7'd5;
    localparam logic [6:0] SLOT_B1  = 7'd9;
    localparam logic [6:0] SLOT_B2  = 7'd27;
    localparam logic [6:0] SLOT_K1  = 7'd30;
    localparam logic [6:0] SLOT_K2  = 7'd33;
    localparam logic [6:0] SLOT_M1  = 7'd68;

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] PRESYNC = 2'd1;
    localparam logic [1:0] SYNC    = 2'd2;

    // Slot counter successor with wrap at the last slot of the frame.
    function automatic logic [6:0] slot_next(input logic [6:0] s, input logic [6:0] last);
        return (s == last) ? 7'd0 : s + 7'd1;
    endfunction

endpackage

// File: rtl/rxfr_align.sv
// Frame alignment for the rx framer: 48-bit byte shift register, A1A1A1A2A2A2
// detector, HUNT/PRESYNC/SYNC state machine and slot counter.
// With RXFR_LOF_EN defined it also flags unconfirmed frame words seen in SYNC.
module rxfr_align
    import rxframer_pkg::*;
#(
    parameter int unsigned FRM_LEN   = 72,
    parameter int unsigned ALIGN_CNT = 2,
    parameter int unsigned LOSS_CNT  = 4
) (
    input  logic       clk19,
    input  logic       rst_n,
    input  logic [7:0] rdat,
    input  logic       en,
    output logic [6:0] slot,
    output logic [1:0] state,
    output logic       rxsof
`ifdef RXFR_LOF_EN
    ,
    output logic       badword
`endif
);

    localparam logic [6:0] LAST = 7'(FRM_LEN - 1);

    logic [47:0] sr;
    logic [47:0] sr_nxt;
    logic        match;
    logic        at_a2l;
    logic [3:0]  good;
    logic [3:0]  bad;
    logic [3:0]  good_inc;
    logic [3:0]  bad_inc;

    // Frame word detection on the window that includes the byte being accepted
    always_comb begin
        sr_nxt   = {sr[39:0], rdat};
        match    = (sr_nxt == FRAME_WORD);
        at_a2l   = (slot == SLOT_A2L);
        good_inc = good + 4'd1;
        bad_inc  = bad + 4'd1;
    end

    // Shift register, slot counter and alignment state machine
    always_ff @(posedge clk19) begin
        if (!rst_n) begin
            sr    <= '0;
            slot  <= '0;
            state <= HUNT;
            good  <= '0;
            bad   <= '0;
            rxsof <= 1'b0;
        end else begin
            rxsof <= 1'b0;
            if (en) begin
                sr   <= sr_nxt;
                slot <= slot_next(slot, LAST);
                case (state)
                    HUNT: begin
                        if (match) begin
                            slot  <= SLOT_A2L + 7'd1;
                            state <= PRESYNC;
                            good  <= 4'd1;
                        end
                    end
                    PRESYNC: begin
                        if (at_a2l) begin
                            if (match) begin
                                good  <= good_inc;
                                rxsof <= 1'b1;
                                if (good_inc >= 4'(ALIGN_CNT)) begin
                                    state <= SYNC;
                                    bad   <= '0;
                                end
                            end else begin
                                state <= HUNT;
                            end
                        end
                    end
                    SYNC: begin
                        if (at_a2l) begin
                            if (match) begin
                                bad   <= '0;
                                rxsof <= 1'b1;
                            end else begin
                                bad <= bad_inc;
                                if (bad_inc >= 4'(LOSS_CNT)) begin
                                    state <= HUNT;
                                end
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef RXFR_LOF_EN
    // One-cycle flag for each frame word missed while in SYNC
    always_ff @(posedge clk19) begin
        if (!rst_n) begin
            badword <= 1'b0;
        end else begin
            badword <= en && (state == SYNC) && at_a2l && !match;
        end
    end
`endif

endmodule

// File: rtl/rxframer.sv
// Receive-side STM-1 overhead framer top: alignment sub-block plus
// B1/B2/K1K2/M1 extraction and out-of-frame reporting.
// Optional loss-of-frame logic is built when RXFR_LOF_EN is defined.
module rxframer
    import rxframer_pkg::*;
#(
    parameter int unsigned FRM_LEN   = 72,
    parameter int unsigned ALIGN_CNT = 2,
    parameter int unsigned LOSS_CNT  = 4,
    parameter int unsigned LOF_FRM   = 8
) (
    input  logic        clk19,
    input  logic        rst_n,
    input  logic [7:0]  rdat,
    input  logic        en,
    output logic        rxsof,
    output logic        oof,
    output logic        lof,
    output logic [7:0]  b1dat,
    output logic        b1vld,
    output logic [23:0] b2dat,
    output logic        b2vld,
    output logic [15:0] k1k2,
    output logic [7:0]  m1dat,
    output logic        m1vld
);

    logic [6:0]  slot;
    logic [1:0]  state;
    logic [15:0] b2hold;
    logic [1:0]  b2stage;
`ifdef RXFR_LOF_EN
    logic        badword;
`endif

    rxfr_align #(
        .FRM_LEN   (FRM_LEN),
        .ALIGN_CNT (ALIGN_CNT),
        .LOSS_CNT  (LOSS_CNT)
    ) u_align (
        .clk19   (clk19),
        .rst_n   (rst_n),
        .rdat    (rdat),
        .en      (en),
        .slot    (slot),
        .state   (state),
        .rxsof   (rxsof)
`ifdef RXFR_LOF_EN
        ,
        .badword (badword)
`endif
    );

    // Out-of-frame indication, one cycle behind the alignment state
    always_ff @(posedge clk19) begin
        if (!rst_n) begin
            oof <= 1'b1;
        end else begin
            oof <= (state != SYNC);
        end
    end

    // Overhead byte extraction while aligned; B2 needs all three bytes of one frame
    always_ff @(posedge clk19) begin
        if (!rst_n) begin
            b1dat   <= '0;
            b1vld   <= 1'b0;
            b2dat   <= '0;
            b2vld   <= 1'b0;
            b2hold  <= '0;
            b2stage <= '0;
            k1k2    <= '0;
            m1dat   <= '0;
            m1vld   <= 1'b0;
        end else begin
            b1vld <= 1'b0;
            b2vld <= 1'b0;
            m1vld <= 1'b0;
            if (state == HUNT) begin
                b2stage <= '0;
            end else if (en) begin
                case (slot)
                    SLOT_B1: begin
                        b1dat <= rdat;
                        b1vld <= 1'b1;
                    end
                    SLOT_B2: begin
                        b2hold[15:8] <= rdat;
                        b2stage      <= 2'd1;
                    end
                    SLOT_B2 + 7'd1: begin
                        if (b2stage == 2'd1) begin
                            b2hold[7:0] <= rdat;
                            b2stage     <= 2'd2;
                        end else begin
                            b2stage <= '0;
                        end
                    end
                    SLOT_B2 + 7'd2: begin
                        if (b2stage == 2'd2) begin
                            b2dat <= {b2hold, rdat};
                            b2vld <= 1'b1;
                        end
                        b2stage <= '0;
                    end
                    SLOT_K1: begin
                        if (state == SYNC) k1k2[15:8] <= rdat;
                    end
                    SLOT_K2: begin
                        if (state == SYNC) k1k2[7:0] <= rdat;
                    end
                    SLOT_M1: begin
                        m1dat <= rdat;
                        m1vld <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RXFR_LOF_EN
    localparam int unsigned OK_FRM = ALIGN_CNT + LOSS_CNT;

    logic [7:0] oofcnt;
    logic [7:0] okcnt;
    logic       wrap;

    assign wrap = en && (slot == 7'(FRM_LEN - 1));

    // Loss-of-frame: set after LOF_FRM wrapped frames out of frame,
    // cleared after OK_FRM clean frames in SYNC
    always_ff @(posedge clk19) begin
        if (!rst_n) begin
            oofcnt <= '0;
            okcnt  <= '0;
            lof    <= 1'b0;
        end else begin
            if (!oof) begin
                oofcnt <= '0;
            end else if (wrap && (oofcnt != 8'(LOF_FRM))) begin
                oofcnt <= oofcnt + 8'd1;
            end
            if (oof || badword) begin
                okcnt <= '0;
            end else if (wrap && (okcnt != 8'(OK_FRM))) begin
                okcnt <= okcnt + 8'd1;
            end
            if (oofcnt == 8'(LOF_FRM)) begin
                lof <= 1'b1;
            end else if (okcnt == 8'(OK_FRM)) begin
                lof <= 1'b0;
            end
        end
    end
`else
    assign lof = 1'b0;
`endif

endmodule
